ps2_frame_rx: RTL and testbench
===============================

Name: ps2_frame_rx

Overview:
- Upstream receive stage of the PS/2 keyboard path; sits between the pad-level ps2_clk/ps2_data pins and the scan-code/display logic.
- Synchronises the PS/2 lines, deserialises 11-bit frames and validates start/parity/stop.
- Buffers accepted scan-code bytes in a small FIFO and presents them over a valid/ready-style pop interface.
- Reports frame errors, timeouts and overflow to the consumer.

Parameters:
- ADDR_W, 3, log2 of FIFO depth (depth = 8 entries).
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from pad, asynchronous.
- ps2_data  in  1  raw PS/2 data from pad, asynchronous.
- rd_en  in  1  consumer pop request; honoured only when valid=1.
- clr_ovf  in  1  clears the sticky overflow flag.
- rdata  out  8  scan code at FIFO head; combinational from storage, stable while valid and no pop.
- valid  out  1  FIFO not empty.
- count  out  ADDR_W+1  FIFO occupancy, 0..8.
- frame_err  out  1  one-cycle pulse on a bad frame or timeout.
- overflow  out  1  sticky; set when a good frame is dropped because the FIFO is full.

Behaviour:
- Reset (async, rst=1): FIFO pointers and count=0, valid=0, bit counter=0, shift register=0, timeout counter=0, frame_err=0, overflow=0. Synchroniser flops reset to 1 (idle line level). Reset mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops. A third ps2_clk history flop detects a falling edge when hist=1 and sync=0. Edge-detect latency from the pin is 3 clk cycles.
- Deserialiser:
  - States: IDLE (bitcnt=0) and RECV (bitcnt 1..10).
  - On each falling edge, the synced ps2_data is shifted into frame[bitcnt] and bitcnt increments.
  - Bit order: bit0 = start, bits 1..8 = data LSB first, bit9 = odd parity, bit10 = stop.
- Frame check (on the falling edge that captures bit10, same cycle):
  - good = (start==0) && (stop==1) && (^{data,parity}==1).
  - bitcnt returns to 0 in that cycle regardless of the result.
- Good frame: pushed in the following cycle.
  - Push accepted if !full || pop_this_cycle. Simultaneous push and pop when full therefore succeeds and count is unchanged.
  - If full with no pop: byte dropped and overflow set to 1.
- Bad frame: frame_err=1 for exactly one cycle; no push.
- Timeout:
  - Counter runs only while bitcnt!=0 and clears on every falling edge.
  - On reaching TIMEOUT_CYCLES-1: bitcnt=0, counter=0, frame_err pulse.
  - The counter saturates; it never wraps.
- FIFO:
  - Circular buffer with ADDR_W-bit pointers that wrap modulo depth.
  - pop = rd_en && valid; rd_en while empty is ignored with no pointer change.
  - count +1 on push only, -1 on pop only, unchanged on both.
  - Writing into an empty FIFO makes valid=1 the cycle after the push and rdata shows the new byte then (first-word fall-through).
- Overflow flag: cleared by clr_ovf. If clr_ovf and a new overflow event occur in the same cycle, set wins.
- Latency: last ps2_clk falling edge at the pin to valid=1 is 5 clk cycles (3 sync/edge + 1 check + 1 write).

Decomposition:
- Package ps2_pkg holds:
  - FRAME_BITS=11
  - BREAK_CODE=8'hF0
  - EXT_CODE=8'hE0
  - a localparam for sync depth (2)
- Sub-module sync_fifo (parameters ADDR_W and DATA_W=8) implements storage, pointers, count and push/pop arbitration.
- Synchroniser, edge detect, deserialiser and timeout stay in ps2_frame_rx.

Test Plan:
- Reset then one frame of 0x1C: bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1 -> valid=1, rdata=8'h1C, count=1, frame_err never high. Then rd_en for 1 cycle -> valid=0, count=0.
- Break sequence, frames F0 then 1C with no pops -> count=2. Pops return 8'hF0 then 8'h1C in order.
- Frame 0x1C with parity bit 1 -> one-cycle frame_err pulse, count stays 0. A following correct 0x32 frame -> rdata=8'h32.
- Nine good frames 0x01..0x09 with no pops -> count=8, overflow=1, and the pop sequence yields 0x01..0x08. Pulse clr_ovf -> overflow=0. A ninth frame arriving while rd_en pops in the same cycle -> accepted, count stays 8, overflow stays 0.
- Five falling edges then idle for TIMEOUT_CYCLES (sim value 100) -> frame_err pulse, no push. The next full 0x1C frame is received correctly.
- rst asserted after 6 bits of a frame -> all outputs return to reset values immediately (asynchronous). After release, a full 0x5A frame gives rdata=8'h5A with count=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, frame layout and frame-check helper for the PS/2 receive path.
package ps2_pkg;

  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned BITCNT_W    = $clog2(FRAME_BITS);

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  // Wire order of a frame: start lands in bit 0, stop in bit 10
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  function automatic logic frame_good(input ps2_frame_t f);
    return !f.start && f.stop && (^{f.data, f.parity});
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with first-word fall-through read and push/pop arbitration.
module sync_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop_req,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic [ADDR_W:0]   count,
  output logic              drop_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              full_c;
  logic              pop_c;
  logic              push_ok_c;

  assign valid     = (count_q != '0);
  assign full_c    = (count_q == (ADDR_W + 1)'(DEPTH));
  assign pop_c     = pop_req && valid;
  // A full FIFO still takes a push when a pop frees the slot in the same cycle
  assign push_ok_c = push && (!full_c || pop_c);
  assign drop_c    = push && full_c && !pop_c;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, 11-bit frame deserialiser/validator with timeout,
// feeding accepted scan codes into a small FIFO with sticky overflow.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [7:0]        rdata,
  output logic              valid,
  output logic [ADDR_W:0]   count,
  output logic              frame_err,
  output logic              overflow
);

  localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_hist_q;
  logic                   fall_q;
  logic                   data_s;

  rx_state_e              state_q, state_d;
  logic [BITCNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-2:0]  frame_q, frame_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   push_q, push_d;
  logic [7:0]             push_byte_q, push_byte_d;
  logic                   err_q, err_d;
  logic                   overflow_q;
  logic                   drop_c;
  ps2_frame_t             frame_chk;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_hist_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
      fall_q      <= clk_hist_q && !clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign frame_chk = ps2_frame_t'({data_s, frame_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      bitcnt_q    <= '0;
      frame_q     <= '0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      frame_q     <= frame_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      err_q       <= err_d;
    end
  end

  // Deserialiser: one bit per ps2_clk falling edge, verdict on the stop bit
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    frame_d     = frame_q;
    tmo_d       = tmo_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    err_d       = 1'b0;

    if (fall_q) begin
      tmo_d = '0;
      if (bitcnt_q == LAST_BIT) begin
        state_d  = RX_IDLE;
        bitcnt_d = '0;
        if (frame_good(frame_chk)) begin
          push_d      = 1'b1;
          push_byte_d = frame_chk.data;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        frame_d[bitcnt_q] = data_s;
        bitcnt_d          = bitcnt_q + 1'b1;
        state_d           = RX_RECV;
      end
    end else if (state_q == RX_RECV) begin
      // Abort at the last count, so the counter can never wrap
      if (tmo_q == TMO_LAST) begin
        state_d  = RX_IDLE;
        bitcnt_d = '0;
        tmo_d    = '0;
        err_d    = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  sync_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .wdata   (push_byte_q),
    .pop_req (rd_en),
    .rdata   (rdata),
    .valid   (valid),
    .count   (count),
    .drop_c  (drop_c)
  );

  // Sticky overflow; a new drop beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign frame_err = err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised scoreboard bench for ps2_frame_rx: a queue model of accepted bytes,
// a pop monitor comparing head data, and state checkpoints between frames.
module tb_ps2_frame_rx;
  import ps2_pkg::*;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TMO    = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            ps2_clk;
  logic            ps2_data;
  logic            rd_en;
  logic            clr_ovf;
  logic [7:0]      rdata;
  logic            valid;
  logic [ADDR_W:0] count;
  logic            frame_err;
  logic            overflow;

  ps2_frame_rx #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .rdata     (rdata),
    .valid     (valid),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         exp_ovf = 0;
  int         exp_err = 0;
  int         err_seen = 0;
  logic [7:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Pop monitor: every honoured pop must return the oldest expected byte
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (frame_err) err_seen++;
      if (rd_en && valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected no data at %0t", rdata, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("pop_data", int'(rdata), int'(mon_exp));
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input bit pop_at_fall);
    int hi;
    int lo;
    hi = $urandom_range(3, 8);
    lo = $urandom_range(3, 8);
    @(negedge clk);
    ps2_data = b;
    repeat (hi) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_at_fall) begin
      // Lands rd_en on the clock edge that writes this frame's byte
      repeat (4) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end else begin
      repeat (lo) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f[0]   = (kind == 2);
    f[8:1] = b;
    f[9]   = (~^b) ^ (kind == 1);
    f[10]  = (kind != 3);
    return f;
  endfunction

  // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
  task automatic send_frame(input logic [7:0] b, input int kind, input bit pop_at_end);
    logic [10:0] f;
    f = build_frame(b, kind);
    for (int i = 0; i < 11; i++) drive_bit(f[i], pop_at_end && (i == 10));
    repeat (8) @(negedge clk);
    if (kind != 0) exp_err++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = build_frame(b, 0);
    for (int i = 0; i < nbits; i++) drive_bit(f[i], 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    exp_ovf = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_state(input string tag);
    #1;
    check({tag, "_count"}, int'(count), exp_q.size());
    check({tag, "_ovf"}, int'(overflow), exp_ovf);
    check({tag, "_err"}, err_seen, exp_err);
    if (exp_q.size() > 0) begin
      check({tag, "_valid"}, int'(valid), 1);
      check({tag, "_rdata"}, int'(rdata), int'(exp_q[0]));
    end else begin
      check({tag, "_valid"}, int'(valid), 0);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_state("reset");

    // Single good frame, then drain
    send_frame(8'h1C, 0, 1'b0);
    expect_state("one_frame");
    pop_one();
    expect_state("one_pop");

    // Break sequence queued, popped in order
    send_frame(BREAK_CODE, 0, 1'b0);
    send_frame(8'h1C, 0, 1'b0);
    expect_state("break_two");
    pop_one();
    pop_one();
    expect_state("break_drain");

    // Parity error followed by a good frame
    send_frame(8'h1C, 1, 1'b0);
    expect_state("parity_err");
    send_frame(8'h32, 0, 1'b0);
    expect_state("after_err");
    pop_one();

    // Overflow on the ninth frame, drain, clear
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0);
    expect_state("overflow");
    for (int i = 0; i < 8; i++) pop_one();
    expect_state("ovf_drain");
    pulse_clr();
    expect_state("ovf_clear");

    // Full FIFO with a pop coinciding with the write: accepted, no overflow
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 0, 1'b0);
    expect_state("refill");
    send_frame(8'h19, 0, 1'b1);
    expect_state("push_pop_full");
    for (int i = 0; i < 8; i++) pop_one();
    expect_state("refill_drain");

    // Timeout on a partial frame, then recovery
    send_partial(8'h1C, 5);
    repeat (TMO + 20) @(negedge clk);
    exp_err++;
    expect_state("timeout");
    send_frame(8'h1C, 0, 1'b0);
    expect_state("after_timeout");
    pop_one();

    // Asynchronous reset mid-frame
    send_frame(8'h77, 0, 1'b1);
    send_partial(8'h5A, 6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 0;
    #1;
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_count", int'(count), 0);
    check("async_rst_err", int'(frame_err), 0);
    check("async_rst_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h5A, 0, 1'b0);
    expect_state("after_rst");
    pop_one();

    // Randomised frames, errors, pops (including pops on empty) and clears
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      int         kind;
      int         npop;
      b    = ($urandom_range(0, 7) == 0) ? EXT_CODE : 8'($urandom);
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(b, kind, 1'b0);
      expect_state("rand_frame");
      if ($urandom_range(0, 2) == 0) begin
        npop = $urandom_range(0, exp_q.size() + 1);
        for (int k = 0; k < npop; k++) pop_one();
        expect_state("rand_pop");
      end
      if ($urandom_range(0, 5) == 0) begin
        pulse_clr();
        expect_state("rand_clr");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
